// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side definitions: opcodes, sequencer states and the pc step.
package mips_pkg;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc selection: sequential, conditional branch or absolute jump.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc4        = pc + PC_STEP;
    // Word offset, sign-extended; the add wraps modulo 2^32 in both directions.
    assign br_offset  = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target  = pc4 + br_offset;
    assign jmp_target = {pc4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        case (opcode(instr))
            OP_BEQ:        if (alu_zero)  next_pc = br_target;
            OP_BNE:        if (!alu_zero) next_pc = br_target;
            OP_J, OP_JAL:  next_pc = jmp_target;
            default:       next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT FSM, pc register with valid/ready fetch
// handshake and a wrapping retired-instruction counter.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc,
    output logic             pc_valid,
    input  logic             pc_ready,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [31:0]      next_pc;
    logic             accept;

    next_pc_calc u_next_pc_calc (
        .pc       (pc_q),
        .instr    (instr),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    // instr/alu_zero only influence state through this gate, so X off-accept is harmless.
    assign accept = valid_q & pc_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (opcode(instr) == OP_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
        valid_d  = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = valid_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected pc/retired pushed on drive, popped after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_ready;
    logic [31:0] instr;
    logic        alu_zero;

    logic [31:0] pc, pc_w;
    logic        pc_valid, valid_w;
    logic        halted, halted_w;
    logic [15:0] retired;
    logic [1:0]  retired_w;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .pc_valid (pc_valid),
        .pc_ready (pc_ready),
        .instr    (instr),
        .alu_zero (alu_zero),
        .halted   (halted),
        .retired  (retired)
    );

    // Second instance: top-of-memory reset pc and a 2-bit counter to reach both wraps quickly.
    pc_sequencer #(
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_W    (2)
    ) dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc_w),
        .pc_valid (valid_w),
        .pc_ready (pc_ready),
        .instr    (instr),
        .alu_zero (alu_zero),
        .halted   (halted_w),
        .retired  (retired_w)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'b0, imm};
    endfunction

    function automatic logic [31:0] ins_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Reference next-pc model written straight from the instruction semantics.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i,
                                                input logic z);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = p + 32'd4;
        off = {{14{i[15]}}, i[15:0], 2'b00};
        case (i[31:26])
            6'h04:        return z ? p4 + off : p4;
            6'h05:        return z ? p4 : p4 + off;
            6'h02, 6'h03: return {p4[31:28], i[25:0], 2'b00};
            6'h3F:        return p;
            default:      return p4;
        endcase
    endfunction

    task automatic do_accept(input logic [31:0] ins, input logic z, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        n = 0;
        while (!pc_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_valid"}, 32'(pc_valid), 32'd1);
        e.pc  = model_next(exp_pc, ins, z);
        e.ret = (exp_ret + 32'd1) & 32'h0000_FFFF;
        e.tag = tag;
        sb_q.push_back(e);
        instr    = ins;
        alu_zero = z;
        pc_ready = 1'b1;
        @(posedge clk);
        #1;
        pc_ready = 1'b0;
        instr    = 32'hx;
        alu_zero = 1'bx;
        got = sb_q.pop_front();
        check_eq({got.tag, "_pc"}, pc, got.pc);
        check_eq({got.tag, "_ret"}, 32'(retired), got.ret);
        exp_pc  = got.pc;
        exp_ret = got.ret;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        pc_ready = 1'b1;
        instr    = 32'h0;
        alu_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_valid", 32'(pc_valid), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_ret", 32'(retired), 32'd0);
        check_eq("rst_pc_w", pc_w, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("boot_valid", 32'(pc_valid), 32'd1);
        check_eq("boot_pc", pc, 32'h0);
        pc_ready = 1'b0;
        exp_pc   = 32'h0;
        exp_ret  = 32'h0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] r;
        logic [31:0] wrap_pc [4];
        logic [31:0] wrap_ret [4];
        ops      = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08};
        wrap_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
        wrap_ret = '{32'd1, 32'd2, 32'd3, 32'd0};

        do_reset();

        // Sequential run with a 5-cycle stall at pc=8; the wrap instance follows in lockstep.
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 5; s++) begin
                    instr    = $urandom();
                    alu_zero = 1'bx;
                    @(posedge clk);
                    #1;
                    check_eq("stall_pc", pc, 32'h8);
                    check_eq("stall_ret", 32'(retired), 32'd2);
                end
            end
            do_accept(ins_i(6'h00, 16'h0), 1'b0, "seq");
            check_eq("seq_pc_const", pc, 32'(4 * (k + 1)));
            check_eq("wrap_pc", pc_w, wrap_pc[k]);
            check_eq("wrap_ret", 32'(retired_w), wrap_ret[k]);
        end

        do_accept(ins_i(6'h04, 16'hFFFC), 1'b1, "beq_t");
        check_eq("beq_t_const", pc, 32'h4);
        repeat (3) do_accept(ins_i(6'h00, 16'h0), 1'b0, "seq2");
        do_accept(ins_i(6'h04, 16'hFFFC), 1'b0, "beq_nt");
        check_eq("beq_nt_const", pc, 32'h14);
        do_accept(ins_i(6'h04, 16'hFFFE), 1'b1, "beq_back");
        check_eq("beq_back_const", pc, 32'h10);
        do_accept(ins_i(6'h05, 16'h0002), 1'b0, "bne_t");
        check_eq("bne_t_const", pc, 32'h1C);
        do_accept(ins_j(6'h02, 26'h10), 1'b0, "j40");
        check_eq("j40_const", pc, 32'h40);
        do_accept(ins_j(6'h02, 26'h100), 1'b1, "j400");
        check_eq("j400_const", pc, 32'h400);
        do_accept(ins_i(6'h05, 16'h0005), 1'b1, "bne_nt");
        check_eq("bne_nt_const", pc, 32'h404);
        do_accept(ins_j(6'h03, 26'h8), 1'b0, "jal");
        check_eq("jal_const", pc, 32'h20);

        do_accept(ins_i(6'h3F, 16'h0), 1'b0, "halt");
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_valid", 32'(pc_valid), 32'd0);
        pc_ready = 1'b1;
        instr    = 32'h0;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk);
            #1;
            check_eq("hold_pc", pc, 32'h20);
            check_eq("hold_valid", 32'(pc_valid), 32'd0);
            check_eq("hold_halted", 32'(halted), 32'd1);
            check_eq("hold_ret", 32'(retired), 32'd16);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("halt_rst_pc", pc, 32'h0);
        check_eq("halt_rst_halted", 32'(halted), 32'd0);

        do_reset();

        // Random mix of opcodes with random stall gaps, checked against the model.
        for (int k = 0; k < 16; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int s = 0; s < gap; s++) begin
                pc_ready = 1'b0;
                instr    = $urandom();
                alu_zero = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                check_eq("rnd_stall_pc", pc, exp_pc);
            end
            r = $urandom();
            do_accept({ops[$urandom_range(0, 5)], r[25:0]}, 1'($urandom_range(0, 1)), "rnd");
        end

        // Reset while a transaction is pending and stalled.
        pc_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_valid", 32'(pc_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_pc", pc, 32'h0);
        check_eq("mid_rst_ret", 32'(retired), 32'd0);
        check_eq("mid_rst_valid", 32'(pc_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
